// File: rtl/uart_rx_packetizer_if.sv
// Byte-in / word-out bundle between the UART receiver, the packetizer and the flash writer.
// master is the packetizer side; slave is the receiver/flash-writer environment.
interface uart_rx_packetizer_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [31:0] word_addr;
    logic        word_last;
    logic        pkt_done;
    logic        pkt_err;
    logic [1:0]  err_code;

    modport master (
        input  rx_valid, rx_data, word_ready,
        output word_valid, word_data, word_addr, word_last, pkt_done, pkt_err, err_code
    );

    modport slave (
        output rx_valid, rx_data, word_ready,
        input  word_valid, word_data, word_addr, word_last, pkt_done, pkt_err, err_code
    );
endinterface

// File: rtl/uart_rx_packetizer.sv
// Parses SYNC/ADDR/LEN/payload/CSUM frames from the UART byte stream and emits
// addressed little-endian 32-bit words through a single-entry output slot.
module uart_rx_packetizer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input logic             clk,
    input logic             rst,
    uart_rx_packetizer_if.master bus
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CSUM} state_t;

    state_t          state, state_nxt;
    logic [31:0]     addr;
    logic [15:0]     len;
    logic [15:0]     word_idx;
    logic [1:0]      byte_idx;
    logic [23:0]     shreg;
    logic [7:0]      csum;
    logic [IW-1:0]   idle_cnt;

    logic            word_valid, word_last, pkt_done, pkt_err;
    logic [31:0]     word_data, word_addr;
    logic [1:0]      err_code;

    logic            word_cplt, slot_busy, is_last, is_sync;
    logic            load_word, ovr, csum_ok, csum_bad, tmo;

    assign word_cplt = (state == DATA) && bus.rx_valid && (byte_idx == 2'd3);
    // slot is only a blocker if it is not being drained in this same cycle
    assign slot_busy = word_valid && !bus.word_ready;
    assign is_last   = (word_idx == len - 16'd1);
    assign is_sync   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);

    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        ovr       = 1'b0;
        csum_ok   = 1'b0;
        csum_bad  = 1'b0;
        tmo       = 1'b0;
        case (state)
            HUNT: if (is_sync) state_nxt = ADDR;
            ADDR: if (bus.rx_valid && byte_idx == 2'd3) state_nxt = LEN;
            LEN:  if (bus.rx_valid && byte_idx == 2'd1)
                      state_nxt = ({bus.rx_data, len[15:8]} == 16'd0) ? CSUM : DATA;
            DATA: if (word_cplt) begin
                      if (slot_busy) begin
                          ovr       = 1'b1;
                          state_nxt = HUNT;
                      end else begin
                          load_word = 1'b1;
                          if (is_last) state_nxt = CSUM;
                      end
                  end
            CSUM: if (bus.rx_valid) begin
                      state_nxt = HUNT;
                      if (bus.rx_data == csum) csum_ok  = 1'b1;
                      else                     csum_bad = 1'b1;
                  end
            default: state_nxt = HUNT;
        endcase
        // a byte arriving in the expiry cycle wins over the timeout
        if (state != HUNT && !bus.rx_valid && idle_cnt == IDLE_LAST) begin
            tmo       = 1'b1;
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            addr       <= '0;
            len        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state    <= state_nxt;
            pkt_done <= csum_ok;
            pkt_err  <= csum_bad | ovr | tmo;
            if (csum_bad) err_code <= 2'd1;
            if (ovr)      err_code <= 2'd2;
            if (tmo)      err_code <= 2'd3;

            if (bus.rx_valid || state == HUNT || state_nxt == HUNT) idle_cnt <= '0;
            else                                                     idle_cnt <= idle_cnt + IW'(1);

            if (word_valid && bus.word_ready) word_valid <= 1'b0;
            if (load_word) begin
                word_valid <= 1'b1;
                word_data  <= {bus.rx_data, shreg};
                word_addr  <= addr + {14'd0, word_idx, 2'b00};
                word_last  <= is_last;
                word_idx   <= word_idx + 16'd1;
            end

            if (bus.rx_valid) begin
                case (state)
                    HUNT: if (is_sync) begin
                              csum     <= '0;
                              byte_idx <= '0;
                              word_idx <= '0;
                              err_code <= 2'd0;
                          end
                    ADDR: begin
                              addr     <= {bus.rx_data, addr[31:8]};
                              csum     <= csum ^ bus.rx_data;
                              byte_idx <= byte_idx + 2'd1;
                          end
                    LEN:  begin
                              len      <= {bus.rx_data, len[15:8]};
                              csum     <= csum ^ bus.rx_data;
                              byte_idx <= (byte_idx == 2'd1) ? 2'd0 : byte_idx + 2'd1;
                          end
                    DATA: begin
                              shreg    <= {bus.rx_data, shreg[23:8]};
                              csum     <= csum ^ bus.rx_data;
                              byte_idx <= byte_idx + 2'd1;
                          end
                    default: ;
                endcase
            end
        end
    end

    assign bus.word_valid = word_valid;
    assign bus.word_data  = word_data;
    assign bus.word_addr  = word_addr;
    assign bus.word_last  = word_last;
    assign bus.pkt_done   = pkt_done;
    assign bus.pkt_err    = pkt_err;
    assign bus.err_code   = err_code;
endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Bench for uart_rx_packetizer: table of framed packets, directed overrun/timeout/reset
// sequences, and random frames checked against a frame-level reference model.
module tb_uart_rx_packetizer;
    localparam int T = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_packetizer_if bus();

    uart_rx_packetizer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [7:0]  b [16];
        int          n;
        int          nw;
        logic [31:0] d [2];
        logic [31:0] a [2];
        logic        l [2];
        int          done;
        int          err;
        logic [1:0]  code;
    } vec_t;

    word_t got[$];
    int    n_done, n_err;
    int    total = 0;
    int    bad   = 0;

    // observed side: accepted words and pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.word_valid && bus.word_ready)
                got.push_back('{last: bus.word_last, addr: bus.word_addr, data: bus.word_data});
            if (bus.pkt_done) n_done++;
            if (bus.pkt_err)  n_err++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_gap(input logic [7:0] b);
        idle($urandom_range(0, 3));
        send(b);
    endtask

    task automatic clear_obs();
        got    = {};
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic check_result(input string tag, input word_t exp_q[$], input int exp_done,
                                input int exp_err, input logic [1:0] exp_code);
        check({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_data"}, 64'(got[i].data), 64'(exp_q[i].data));
            check({tag, "_addr"}, 64'(got[i].addr), 64'(exp_q[i].addr));
            check({tag, "_last"}, 64'(got[i].last), 64'(exp_q[i].last));
        end
        check({tag, "_ndone"}, 64'(n_done), 64'(exp_done));
        check({tag, "_nerr"}, 64'(n_err), 64'(exp_err));
        check({tag, "_code"}, 64'(bus.err_code), 64'(exp_code));
    endtask

    task automatic good_packet();
        logic [7:0] g [16];
        g = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11,
              8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        for (int i = 0; i < 16; i++) send(g[i]);
    endtask

    vec_t        vec [5];
    word_t       exp_q[$];
    word_t       w;
    logic [7:0]  pl[$];
    logic [7:0]  cs, jb;
    logic [31:0] a;
    int          len, nj, cnt;
    bit          corrupt;

    initial begin
        vec[0].b = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11,
                     8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        vec[0].n = 16; vec[0].nw = 2;
        vec[0].d = '{32'h44332211, 32'h88776655}; vec[0].a = '{32'h1000, 32'h1004};
        vec[0].l = '{1'b0, 1'b1}; vec[0].done = 1; vec[0].err = 0; vec[0].code = 2'd0;

        vec[1] = vec[0];
        vec[1].b[15] = 8'h9B; vec[1].done = 0; vec[1].err = 1; vec[1].code = 2'd1;

        vec[2].b = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[2].n = 10; vec[2].nw = 0;
        vec[2].d = '{32'h0, 32'h0}; vec[2].a = '{32'h0, 32'h0}; vec[2].l = '{1'b0, 1'b0};
        vec[2].done = 1; vec[2].err = 0; vec[2].code = 2'd0;

        // address wraps past 2^32 on the second word
        vec[3].b = '{8'hA5, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01,
                     8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        vec[3].n = 16; vec[3].nw = 2;
        vec[3].d = '{32'h04030201, 32'h08070605}; vec[3].a = '{32'hFFFFFFFC, 32'h0};
        vec[3].l = '{1'b0, 1'b1}; vec[3].done = 1; vec[3].err = 0; vec[3].code = 2'd0;

        // SYNC value inside the payload is plain data
        vec[4].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA5,
                     8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[4].n = 12; vec[4].nw = 1;
        vec[4].d = '{32'hA5A5A5A5, 32'h0}; vec[4].a = '{32'h0, 32'h0}; vec[4].l = '{1'b1, 1'b0};
        vec[4].done = 1; vec[4].err = 0; vec[4].code = 2'd0;

        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.word_ready = 1'b1;
        clear_obs();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_word_valid", 64'(bus.word_valid), 64'd0);
        check("rst_word_last", 64'(bus.word_last), 64'd0);
        check("rst_word_data", 64'(bus.word_data), 64'd0);
        check("rst_word_addr", 64'(bus.word_addr), 64'd0);
        check("rst_pkt_done", 64'(bus.pkt_done), 64'd0);
        check("rst_pkt_err", 64'(bus.pkt_err), 64'd0);
        check("rst_err_code", 64'(bus.err_code), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        for (int k = 0; k < 5; k++) begin
            clear_obs();
            exp_q = {};
            for (int i = 0; i < vec[k].nw; i++) begin
                w.data = vec[k].d[i]; w.addr = vec[k].a[i]; w.last = vec[k].l[i];
                exp_q.push_back(w);
            end
            for (int i = 0; i < vec[k].n; i++) send(vec[k].b[i]);
            @(negedge clk);
            check("tbl_done_pulse", 64'(bus.pkt_done), 64'(vec[k].done));
            check("tbl_err_pulse", 64'(bus.pkt_err), 64'(vec[k].err));
            @(negedge clk);
            check("tbl_pulse_width", 64'(bus.pkt_done | bus.pkt_err), 64'd0);
            idle(3);
            check_result("tbl", exp_q, vec[k].done, vec[k].err, vec[k].code);
        end

        // overrun: slot never drained, second word collides
        clear_obs();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(vec[0].b[i]);
        for (int i = 7; i < 15; i++) send(vec[0].b[i]);
        @(negedge clk);
        check("ovr_err_pulse", 64'(bus.pkt_err), 64'd1);
        check("ovr_code", 64'(bus.err_code), 64'd2);
        check("ovr_pending_valid", 64'(bus.word_valid), 64'd1);
        check("ovr_pending_data", 64'(bus.word_data), 64'h44332211);
        check("ovr_pending_addr", 64'(bus.word_addr), 64'h1000);
        send(8'h9A);
        idle(3);
        check("ovr_still_valid", 64'(bus.word_valid), 64'd1);
        bus.word_ready = 1'b1;
        idle(2);
        exp_q = {};
        w.data = 32'h44332211; w.addr = 32'h1000; w.last = 1'b0;
        exp_q.push_back(w);
        check_result("ovr", exp_q, 0, 1, 2'd2);
        check("ovr_slot_freed", 64'(bus.word_valid), 64'd0);

        // timeout after partial address
        clear_obs();
        send(8'hA5); send(8'h00); send(8'h10); send(8'h00);
        cnt = 0;
        while (cnt <= T + 10) begin
            @(negedge clk);
            if (bus.pkt_err) break;
            cnt++;
        end
        check("tmo_latency", 64'(cnt), 64'(T));
        check("tmo_code", 64'(bus.err_code), 64'd3);
        idle(2);
        clear_obs();
        good_packet();
        idle(3);
        exp_q = {};
        w.data = 32'h44332211; w.addr = 32'h1000; w.last = 1'b0; exp_q.push_back(w);
        w.data = 32'h88776655; w.addr = 32'h1004; w.last = 1'b1; exp_q.push_back(w);
        check_result("post_tmo", exp_q, 1, 0, 2'd0);

        // bytes arriving exactly at the expiry cycle keep the packet alive
        clear_obs();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) idle(T - 1);
            send(vec[0].b[i]);
        end
        idle(3);
        check_result("slow", exp_q, 1, 0, 2'd0);

        // reset mid-DATA with a word pending
        clear_obs();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 13; i++) send(vec[0].b[i]);
        check("rstmid_pending", 64'(bus.word_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_valid", 64'(bus.word_valid), 64'd0);
        check("rstmid_data", 64'(bus.word_data), 64'd0);
        check("rstmid_addr", 64'(bus.word_addr), 64'd0);
        check("rstmid_pulses", 64'({bus.pkt_done, bus.pkt_err, bus.word_last}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.word_ready = 1'b1;
        idle(3);
        check_result("rstmid", '{}, 0, 0, 2'd0);
        good_packet();
        idle(3);
        check_result("post_rst", exp_q, 1, 0, 2'd0);

        // random frames against the frame-level model
        for (int p = 0; p < 30; p++) begin
            clear_obs();
            exp_q = {};
            pl = {};
            a = $urandom;
            len = $urandom_range(0, 5);
            for (int i = 0; i < len * 4; i++) pl.push_back(8'($urandom));
            cs = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'(len) ^ 8'(len >> 8);
            foreach (pl[i]) cs ^= pl[i];
            for (int i = 0; i < len; i++) begin
                w.data = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
                w.addr = a + 32'(4 * i);
                w.last = (i == len - 1);
                exp_q.push_back(w);
            end
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) cs ^= 8'($urandom_range(1, 255));
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_gap(jb);
            end
            send_gap(8'hA5);
            send_gap(a[7:0]); send_gap(a[15:8]); send_gap(a[23:16]); send_gap(a[31:24]);
            send_gap(8'(len)); send_gap(8'(len >> 8));
            foreach (pl[i]) send_gap(pl[i]);
            send_gap(cs);
            idle(3);
            check_result("rnd", exp_q, corrupt ? 0 : 1, corrupt ? 1 : 0, corrupt ? 2'd1 : 2'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
